// File: rtl/audio_pkg.sv
// Shared types and default sizes for the audio RAM scheduler.
package audio_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } chan_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REC  = 2'd1,
    GNT_PLAY = 2'd2
  } gnt_sel_t;

  localparam int DEF_CLIP_WORDS = 65536;
  localparam int DEF_DATA_W     = 8;

endpackage

// File: rtl/audio_mem_sched_arbiter.sv
// mem_rr_arbiter: 2-way round-robin between record and play with a last-grant pointer.
module mem_rr_arbiter
  import audio_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_rec,
  input  logic req_play,
  output logic gnt_rec,
  output logic gnt_play
);

  gnt_sel_t last_gnt;

  // On a tie the channel that did not win last time gets the port.
  always_comb begin
    gnt_rec  = req_rec  & (~req_play | (last_gnt != GNT_REC));
    gnt_play = req_play & (~req_rec  | (last_gnt == GNT_REC));
  end

  always_ff @(posedge clock) begin
    if (reset)         last_gnt <= GNT_PLAY;
    else if (gnt_rec)  last_gnt <= GNT_REC;
    else if (gnt_play) last_gnt <= GNT_PLAY;
  end

endmodule

// File: rtl/audio_mem_sched.sv
// Record/playback scheduler for the single-port sample RAM.
// Define AUDIO_MEM_SCHED_LOOP_EN to make playback wrap within its clip forever.
module audio_mem_sched
  import audio_pkg::*;
#(
  parameter int CLIP_WORDS = DEF_CLIP_WORDS,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              rec_clip,
  input  logic              play_start,
  input  logic              play_clip,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rec_busy,
  output logic              play_busy,
  output logic              rec_done,
  output logic              play_done,
  output logic              start_err
);

  localparam int OFF_W = $clog2(CLIP_WORDS);

  chan_state_t      rec_state, play_state;
  logic             rec_clip_q, play_clip_q;
  logic [OFF_W-1:0] rec_off, play_off;
  logic [ADDR_W-1:0] addr_q;
  logic             same_starts, rec_ok, play_ok, start_bad;
  logic             req_rec, req_play, gnt_rec, gnt_play;

  // A start is refused if its channel is busy or the other channel owns that clip.
  always_comb begin
    same_starts = rec_start & play_start & (rec_clip == play_clip);
    rec_ok  = rec_start & (rec_state == IDLE) & ~same_starts &
              ~((play_state == ACTIVE) & (play_clip_q == rec_clip));
    play_ok = play_start & (play_state == IDLE) & ~same_starts &
              ~((rec_state == ACTIVE) & (rec_clip_q == play_clip));
    start_bad = (rec_start & ~rec_ok) | (play_start & ~play_ok);
  end

  // Requests are masked during reset so the reset cycle never touches the RAM.
  assign req_rec  = ~reset & (rec_state == ACTIVE) & wr_valid;
  assign req_play = ~reset & (play_state == ACTIVE) & rd_req;

  mem_rr_arbiter u_arb (
    .clock    (clock),
    .reset    (reset),
    .req_rec  (req_rec),
    .req_play (req_play),
    .gnt_rec  (gnt_rec),
    .gnt_play (gnt_play)
  );

  always_comb begin
    wr_ready  = gnt_rec;
    rd_ack    = gnt_play;
    mem_we    = gnt_rec;
    mem_wdata = gnt_rec ? wr_data : '0;
    if (gnt_rec)       mem_addr = {rec_clip_q, rec_off};
    else if (gnt_play) mem_addr = {play_clip_q, play_off};
    else               mem_addr = addr_q;
  end

  assign rd_data   = mem_rdata;
  assign rec_busy  = (rec_state == ACTIVE);
  assign play_busy = (play_state == ACTIVE);

  always_ff @(posedge clock) begin
    if (reset) begin
      rec_state  <= IDLE;
      rec_clip_q <= 1'b0;
      rec_off    <= '0;
      rec_done   <= 1'b0;
    end else begin
      rec_done <= 1'b0;
      case (rec_state)
        IDLE: if (rec_ok) begin
          rec_state  <= ACTIVE;
          rec_clip_q <= rec_clip;
          rec_off    <= '0;
        end
        ACTIVE: if (gnt_rec) begin
          rec_off <= rec_off + 1'b1;
          if (rec_off == '1) begin
            rec_state <= IDLE;
            rec_done  <= 1'b1;
          end
        end
        default: rec_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      play_state  <= IDLE;
      play_clip_q <= 1'b0;
      play_off    <= '0;
      play_done   <= 1'b0;
    end else begin
      play_done <= 1'b0;
      case (play_state)
        IDLE: if (play_ok) begin
          play_state  <= ACTIVE;
          play_clip_q <= play_clip;
          play_off    <= '0;
        end
        ACTIVE: if (gnt_play) begin
          play_off <= play_off + 1'b1;
          if (play_off == '1) begin
`ifdef AUDIO_MEM_SCHED_LOOP_EN
            play_done <= 1'b1;
`else
            play_state <= IDLE;
            play_done  <= 1'b1;
`endif
          end
        end
        default: play_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      rd_valid  <= 1'b0;
      start_err <= 1'b0;
    end else begin
      if (gnt_rec | gnt_play) addr_q <= mem_addr;
      rd_valid  <= gnt_play;
      start_err <= start_bad;
    end
  end

endmodule

// File: doc/audio_mem_sched.md
# audio_mem_sched

Scheduler sharing the single-port audio sample RAM between the record path (deserializer writes) and the playback path (serializer reads). Tracks one record channel and one play channel, each bound to one of two clips. Generates absolute RAM addresses as clip base plus running offset and round-robin arbitrates the one RAM port per cycle. Sits between the top-level mode controller and the sample RAM; replaces fixed start-address handling.

## Interface
- CLIP_WORDS, 65536: words per clip; power of two, ≥ 4.
- ADDR_W, 17: RAM address width; must equal log2(2*CLIP_WORDS).
- DATA_W, 8: sample width.
- clock in 1: sole clock; all logic on rising edge.
- reset in 1: synchronous, active-high; clears all state.
- rec_start in 1: one-cycle pulse; start recording into clip rec_clip.
- rec_clip in 1: target clip, sampled with rec_start.
- play_start in 1: one-cycle pulse; start playback of clip play_clip.
- play_clip in 1: source clip, sampled with play_start.
- wr_valid in 1: deserializer has a sample; held until wr_ready.
- wr_data in DATA_W: sample to write.
- wr_ready out 1: write granted this cycle; sample consumed.
- rd_req in 1: serializer wants next sample; held until rd_ack.
- rd_ack out 1: read granted this cycle.
- rd_valid out 1: rd_data valid; one cycle after rd_ack.
- rd_data out DATA_W: sample (pass-through of mem_rdata).
- mem_addr out ADDR_W: RAM address.
- mem_we out 1: RAM write enable.
- mem_wdata out DATA_W: RAM write data.
- mem_rdata in DATA_W: RAM read data, one-cycle synchronous latency.
- rec_busy / play_busy out 1: channel active.
- rec_done / play_done out 1: one-cycle pulse after the channel's last word.
- start_err out 1: one-cycle pulse when a start is rejected.

## Operation
- Each channel: IDLE or ACTIVE, plus clip register and offset counter of log2(CLIP_WORDS) bits.
- IDLE→ACTIVE on accepted start: clip latched, offset cleared, busy set next cycle.
- Start rejected (start_err pulse, no state change): channel already ACTIVE; or other channel ACTIVE on the same clip. If rec_start and play_start arrive in the same cycle with the same clip, both are rejected. Different clips are both accepted.
- Requesters: record = ACTIVE & wr_valid; play = ACTIVE & rd_req. Inputs from IDLE channels are ignored.
- Arbitration: one grant per cycle.
  - Sole requester wins.
  - On a tie, grant goes to the channel not granted last; the last-grant pointer resets to play, so record wins the first tie.
- Write grant: wr_ready=1, mem_we=1, mem_addr={rec_clip, rec_offset}, mem_wdata=wr_data.
- Read grant: rd_ack=1, mem_we=0, mem_addr={play_clip, play_offset}.
- No grant: mem_we=0, mem_addr holds its last value.
- Offset increments on its channel's grant.
- Grant at offset CLIP_WORDS-1: channel goes IDLE next cycle and its done pulses next cycle. No wrap into the other clip.
- Reset mid-operation: both channels IDLE. The reset cycle produces no grant, mem_we=0, and no done pulse.

## Timing
- Reset values: every output 0, mem_addr 0.
- Start pulse at cycle N: busy at N+1; first grant possible at N+1.
- rd_ack at N: rd_valid=1 and rd_data=mem_rdata at N+1.
- Sustained single channel: one word per cycle. Both saturating: alternate, one word per channel every 2 cycles.
- Outputs wr_ready, rd_ack, mem_we and mem_addr are combinational from registered state plus wr_valid/rd_req. rd_valid, busy, done and start_err are registered.

## Configuration
- AUDIO_MEM_SCHED_LOOP_EN defined: play channel at last word wraps offset to 0 and stays ACTIVE; play_done pulses each wrap. Playback stops only on reset.
- Not defined: play stops at last word as described above.
- The record channel always stops at its last word.

## Structure
- Shared package audio_pkg:
  - channel state enum (IDLE, ACTIVE);
  - grant-select enum (GNT_NONE, GNT_REC, GNT_PLAY);
  - default CLIP_WORDS / DATA_W constants.
- One sub-module: mem_rr_arbiter (2-way round-robin with last-grant pointer); offset counters and FSMs stay in the top.

## Test plan
Bench uses CLIP_WORDS=8, ADDR_W=4.
- Record clip 1 with wr_valid held high and data 0x10..0x17 → wr_ready 8 consecutive cycles; writes to addresses 8..15; rec_done one cycle after the 8th grant; rec_busy low after.
- Play clip 1 with rd_req held high → rd_ack at addresses 8..15; rd_valid one cycle after each; rd_data 0x10..0x17; play_done once.
- Record clip 0 and play clip 1 both saturating → grants alternate REC, PLAY, REC…, record first; each channel finishes in 16 cycles.
- play_start clip 1 while recording clip 1, and a second rec_start while recording → start_err pulses; no state change. Simultaneous same-clip starts → both rejected.
- Reset asserted mid-record at offset 3 → no write that cycle; all outputs 0 next cycle; a new rec_start begins at offset 0.
- With AUDIO_MEM_SCHED_LOOP_EN: play 20 reads of clip 0 → addresses 0..7, 0..7, 0..3; play_done at both wraps; play_busy stays high.
